controladora_multizona: RTL

- Parametrised successor of the single-zone lamp controller; drives NUM_ZONES independent lamp zones from one clock.
- Each zone has its own push button, infrared presence sensor, mode LED and lamp output.
- Per zone: synchroniser, debouncer, short/long press classifier, AUTO/MANUAL mode FSM and auto-shutdown timer. All timing parameters propagate to every zone; none are hard-coded.

---
 rtl/controladora_multizona.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/controladora_multizona.sv
// Multi-zone lamp controller: per-zone synchroniser, debouncer, short/long press classifier,
// AUTO/MANUAL mode FSM and presence-driven auto shutdown. Macro GLOBAL_OFF_EN adds the all_off input.
module controladora_multizona #(
  parameter int NUM_ZONES         = 4,
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5000,
  parameter int AUTO_SHUTDOWN_T   = 30000
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef GLOBAL_OFF_EN
  input  logic                 all_off,
`endif
  input  logic [NUM_ZONES-1:0] infravermelho,
  input  logic [NUM_ZONES-1:0] push_button,
  output logic [NUM_ZONES-1:0] led,
  output logic [NUM_ZONES-1:0] saida
);

  localparam int DW = $clog2(DEBOUNCE_P + 1);
  localparam int PW = $clog2(SWITCH_MODE_MIN_T + 1);
  localparam int TW = $clog2(AUTO_SHUTDOWN_T + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_P - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [PW-1:0] PRESS_MAX = PW'(SWITCH_MODE_MIN_T);
  localparam logic [PW-1:0] PRESS_ONE = PW'(1);
  localparam logic [TW-1:0] TMR_MAX   = TW'(AUTO_SHUTDOWN_T);
  localparam logic [TW-1:0] TMR_LAST  = TW'(AUTO_SHUTDOWN_T - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic {MODE_AUTO = 1'b0, MODE_MANUAL = 1'b1} mode_e;

  logic off_s;

`ifdef GLOBAL_OFF_EN
  logic off_s1_q;
  logic off_s2_q;

  // two-flop synchroniser for the global off request
  always_ff @(posedge clk) begin
    if (rst) begin
      off_s1_q <= 1'b0;
      off_s2_q <= 1'b0;
    end else begin
      off_s1_q <= all_off;
      off_s2_q <= off_s1_q;
    end
  end

  assign off_s = off_s2_q;
`else
  assign off_s = 1'b0;
`endif

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    logic          btn_s1_q, btn_s2_q;
    logic          ir_s1_q, ir_s2_q;
    logic          db_q, db_d, db_prev_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [PW-1:0] press_cnt_q, press_cnt_d;
    logic [TW-1:0] tmr_q;
    mode_e         mode_q;
    logic          saida_q;
    logic          release_s;
    logic          long_s;

    // debouncer and saturating press-length counter next state
    always_comb begin
      db_d        = db_q;
      db_cnt_d    = '0;
      press_cnt_d = '0;
      if (btn_s2_q != db_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_d     = btn_s2_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end else begin
        db_cnt_d = '0;
      end
      if (off_s) begin
        press_cnt_d = '0;
      end else if (db_q) begin
        if (press_cnt_q == PRESS_MAX) begin
          press_cnt_d = press_cnt_q;
        end else begin
          press_cnt_d = press_cnt_q + PRESS_ONE;
        end
      end else begin
        press_cnt_d = '0;
      end
    end

    // press_cnt_q still holds the full press length during the release cycle
    assign release_s = db_prev_q & ~db_q & ~off_s;
    assign long_s    = (press_cnt_q >= PRESS_MAX);

    // synchronisers, debounce state, mode FSM and lamp/timer registers
    always_ff @(posedge clk) begin
      if (rst) begin
        btn_s1_q    <= 1'b0;
        btn_s2_q    <= 1'b0;
        ir_s1_q     <= 1'b0;
        ir_s2_q     <= 1'b0;
        db_q        <= 1'b0;
        db_prev_q   <= 1'b0;
        db_cnt_q    <= '0;
        press_cnt_q <= '0;
        tmr_q       <= '0;
        mode_q      <= MODE_AUTO;
        saida_q     <= 1'b0;
      end else begin
        btn_s1_q    <= push_button[z];
        btn_s2_q    <= btn_s1_q;
        ir_s1_q     <= infravermelho[z];
        ir_s2_q     <= ir_s1_q;
        db_q        <= db_d;
        db_prev_q   <= db_q;
        db_cnt_q    <= db_cnt_d;
        press_cnt_q <= press_cnt_d;
        if (off_s) begin
          mode_q  <= MODE_MANUAL;
          saida_q <= 1'b0;
          tmr_q   <= '0;
        end else if (release_s) begin
          if (long_s) begin
            case (mode_q)
              MODE_AUTO:   mode_q <= MODE_MANUAL;
              MODE_MANUAL: begin
                mode_q <= MODE_AUTO;
                tmr_q  <= '0;
              end
              default:     mode_q <= MODE_AUTO;
            endcase
          end else if (mode_q == MODE_MANUAL) begin
            saida_q <= ~saida_q;
          end
        end else if (mode_q == MODE_AUTO) begin
          if (ir_s2_q) begin
            saida_q <= 1'b1;
            tmr_q   <= '0;
          end else begin
            if (tmr_q != TMR_MAX) begin
              tmr_q <= tmr_q + TMR_ONE;
            end
            // lamp drops on the same edge the timer reaches its limit
            if (tmr_q >= TMR_LAST) begin
              saida_q <= 1'b0;
            end
          end
        end
      end
    end

    assign led[z]   = (mode_q == MODE_MANUAL);
    assign saida[z] = saida_q;
  end

endmodule
